// File: rtl/dcache_if.sv
// dcache_if: CPU data port plus block memory port of the associative data cache.
// Signals:
//   CPU:      read, write, address, writedata -> cache; readdata, busywait <- cache
//   Memory:   mem_read, mem_write, mem_address, mem_writedata <- cache;
//             mem_readdata, mem_busywait -> cache
//   Counters: hit_count, miss_count <- cache
// Modports:
//   slave  = the cache
//   master = the environment (CPU plus memory)
interface dcache_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [7:0]        writedata;
  logic [7:0]        readdata;
  logic              busywait;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-3:0] mem_address;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_busywait;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata,
           hit_count, miss_count
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata,
           hit_count, miss_count
  );
endinterface

// File: rtl/dcache_assoc.sv
// dcache_assoc: 2-way set-associative, write-back, write-allocate data cache.
// The block size is 4 bytes, which is one memory word. Replacement is true LRU per set.
// The hit and miss counters saturate.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high
//   bus   - dcache_if.slave, carrying the CPU request/response, the memory handshake and the counters
module dcache_assoc #(
  parameter int ADDR_W = 8,
  parameter int SETS   = 8,
  parameter int CNT_W  = 16
) (
  input logic     clk,
  input logic     reset,
  dcache_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int WAYS  = 2;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;

  state_t                                 state;
  logic [SETS-1:0][WAYS-1:0]              valid_q, dirty_q;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]   tag_q;
  logic [SETS-1:0][WAYS-1:0][31:0]        data_q;
  logic [SETS-1:0]                        lru_q;    // names the least-recently-used way

  logic              vic_q, seen_busy, missed;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  logic             req, hit, hit_way, victim, complete, mem_done;
  logic [WAYS-1:0]  way_hit;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tg;
  logic [1:0]       off;
  logic [31:0]      hit_data;

  // Both strobes high is treated as no request.
  assign req = bus.read ^ bus.write;
  assign idx = bus.address[IDX_W+1:2];
  assign tg  = bus.address[ADDR_W-1:IDX_W+2];
  assign off = bus.address[1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w] = valid_q[idx][w] && (tag_q[idx][w] == tg);
  end

  assign hit      = |way_hit;
  assign hit_way  = way_hit[1];
  assign hit_data = data_q[idx][hit_way];
  assign victim   = !valid_q[idx][0] ? 1'b0 : !valid_q[idx][1] ? 1'b1 : lru_q[idx];
  assign complete = req && hit && (state == IDLE);
  // A transfer is complete only once memory has shown busy in this state.
  assign mem_done = seen_busy && !bus.mem_busywait;

  assign bus.busywait      = req && ((state != IDLE) || !hit);
  assign bus.readdata      = (bus.read && !bus.write && hit) ? hit_data[{off, 3'b000} +: 8] : 8'd0;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_addr_q;
  assign bus.mem_writedata = mem_wdata_q;
  assign bus.hit_count     = hit_cnt;
  assign bus.miss_count    = miss_cnt;

  // Controller FSM. The memory outputs are registered and stay constant for a whole state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      vic_q       <= 1'b0;
      seen_busy   <= 1'b0;
      missed      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      seen_busy <= seen_busy | bus.mem_busywait;
      case (state)
        IDLE: begin
          if (req && !hit) begin
            // The victim is latched here. The fill must land in the same way even though
            // the lookup inputs are only guaranteed stable, not re-evaluated.
            vic_q     <= victim;
            missed    <= 1'b1;
            seen_busy <= 1'b0;
            if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
              state       <= WRITE_BACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[idx][victim], idx};
              mem_wdata_q <= data_q[idx][victim];
            end else begin
              state      <= MEM_READ;
              mem_read_q <= 1'b1;
              mem_addr_q <= {tg, idx};
            end
          end else if (complete) begin
            missed <= 1'b0;
            if (missed) miss_cnt <= (miss_cnt == '1) ? miss_cnt : miss_cnt + CNT_W'(1);
            else        hit_cnt  <= (hit_cnt  == '1) ? hit_cnt  : hit_cnt  + CNT_W'(1);
          end
        end
        WRITE_BACK: if (mem_done) begin
          state       <= MEM_READ;
          seen_busy   <= 1'b0;
          mem_write_q <= 1'b0;
          mem_wdata_q <= '0;
          mem_read_q  <= 1'b1;
          mem_addr_q  <= {tg, idx};
        end
        MEM_READ: if (mem_done) begin
          state      <= UPDATE;
          seen_busy  <= 1'b0;
          mem_read_q <= 1'b0;
          mem_addr_q <= '0;
        end
        default: begin  // UPDATE
          state     <= IDLE;
          seen_busy <= 1'b0;
        end
      endcase
    end
  end

  // Line storage. The tag and data arrays are not reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else if (state == UPDATE) begin
      valid_q[idx][vic_q] <= 1'b1;
      dirty_q[idx][vic_q] <= 1'b0;
      tag_q[idx][vic_q]   <= tg;
      data_q[idx][vic_q]  <= bus.mem_readdata;
    end else if (complete) begin
      lru_q[idx] <= ~hit_way;
      if (bus.write) begin
        data_q[idx][hit_way][{off, 3'b000} +: 8] <= bus.writedata;
        dirty_q[idx][hit_way]                    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed bench for dcache_assoc with ADDR_W=8, SETS=8 and CNT_W=4.
// The memory answers L cycles after it sees a request.
// The reference model holds the cache contents as plain line arrays plus the backing memory.
// From those it predicts, for each request, the following:
//   - hit or miss
//   - the victim
//   - the stall length
//   - the cycle-by-cycle memory traffic
//   - readdata
//   - the counters
module tb_dcache_assoc;
  localparam int L    = 5;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_if #(.ADDR_W(8), .CNT_W(4)) bus ();
  dcache_assoc #(.ADDR_W(8), .SETS(8), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0, n_fail = 0;

  function automatic logic [31:0] init_word(input logic [5:0] a);
    logic [7:0] b;
    b = {2'b00, a} ^ 8'h01;
    return 32'hDDCCBBAA ^ {4{b}};
  endfunction

  // Memory environment: IDLE -> BUSY for L-1 cycles -> HOLD for the completion edge.
  logic [31:0] mem [64];
  logic [31:0] mrd;
  logic [31:0] mwd;
  logic [5:0]  maddr;
  logic        mbusy;
  logic        mop_wr;
  int          mst, mcnt;
  assign bus.mem_busywait = mbusy;
  assign bus.mem_readdata = mrd;

  always @(posedge clk) begin
    if (reset) begin
      mst   <= 0;
      mbusy <= 1'b0;
      mcnt  <= 0;
      mrd   <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i[5:0]);
    end else begin
      case (mst)
        0: if (bus.mem_read || bus.mem_write) begin
          mst    <= 1;
          mbusy  <= 1'b1;
          mcnt   <= L - 1;
          mop_wr <= bus.mem_write;
          maddr  <= bus.mem_address;
          mwd    <= bus.mem_writedata;
        end
        1: begin
          mcnt <= mcnt - 1;
          if (mcnt == 1) begin
            mbusy <= 1'b0;
            mst   <= 2;
            if (mop_wr) mem[maddr] <= mwd;
            else        mrd        <= mem[maddr];
          end
        end
        default: mst <= 0;
      endcase
    end
  end

  // Reference model
  bit          mv [2][8];
  bit          md [2][8];
  logic [2:0]  mt [2][8];
  logic [31:0] mdat [2][8];
  int          ml [8];
  logic [31:0] em [64];
  int          hc, mc;
  logic [7:0]  last_rd;
  logic [5:0]  last_wba, last_mra;
  logic [31:0] last_wbd;

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        mv[w][s] = 1'b0;
        md[w][s] = 1'b0;
      end
    for (int s = 0; s < 8; s++) ml[s] = 0;
    for (int a = 0; a < 64; a++) em[a] = init_word(a[5:0]);
    hc = 0;
    mc = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge and check every cycle until it completes.
  task automatic do_req(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
    logic [2:0]  s, tg;
    logic [5:0]  wba;
    logic [31:0] wbd, line;
    logic [7:0]  exp_rd;
    int          off, hw, vic, stall, rs;
    bit          dv, ew, er;
    s   = a[4:2];
    tg  = a[7:5];
    off = int'(a[1:0]);
    hw  = -1;
    for (int w = 0; w < 2; w++) if (mv[w][s] && mt[w][s] == tg) hw = w;
    vic = hw;
    dv  = 1'b0;
    wba = '0;
    wbd = '0;
    if (hw < 0) begin
      vic = !mv[0][s] ? 0 : !mv[1][s] ? 1 : ml[s];
      dv  = mv[vic][s] && md[vic][s];
      wba = {mt[vic][s], s};
      wbd = mdat[vic][s];
    end
    stall  = (hw >= 0) ? 0 : dv ? 2*L + 4 : L + 3;
    rs     = dv ? L + 2 : 1;
    line   = (hw >= 0) ? mdat[hw][s] : em[a[7:2]];
    exp_rd = rd ? line[8*off +: 8] : 8'h00;
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = wd;
    for (int c = 0; c <= stall; c++) begin
      #1;
      ew = dv && c >= 1 && c <= L + 1;
      er = (hw < 0) && c >= rs && c <= rs + L;
      chk("busywait", 32'(bus.busywait), 32'(c < stall));
      chk("mem_read", 32'(bus.mem_read), 32'(er));
      chk("mem_write", 32'(bus.mem_write), 32'(ew));
      chk("mem_address", 32'(bus.mem_address), ew ? 32'(wba) : er ? 32'(a[7:2]) : 32'd0);
      chk("mem_writedata", bus.mem_writedata, ew ? wbd : 32'd0);
      if (ew) begin
        last_wba = bus.mem_address;
        last_wbd = bus.mem_writedata;
      end
      if (er) last_mra = bus.mem_address;
      if (c == stall) begin
        chk("readdata", 32'(bus.readdata), 32'(exp_rd));
        last_rd = bus.readdata;
      end else begin
        @(negedge clk);
      end
    end
    @(posedge clk);
    if (hw < 0) begin
      if (dv) em[wba] = wbd;
      mv[vic][s]   = 1'b1;
      md[vic][s]   = 1'b0;
      mt[vic][s]   = tg;
      mdat[vic][s] = em[a[7:2]];
      hw = vic;
      mc = (mc == CMAX) ? CMAX : mc + 1;
    end else begin
      hc = (hc == CMAX) ? CMAX : hc + 1;
    end
    if (wr) begin
      mdat[hw][s][8*off +: 8] = wd;
      md[hw][s] = 1'b1;
    end
    ml[s] = (hw == 0) ? 1 : 0;
    @(negedge clk);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    #1;
    chk("hit_count", 32'(bus.hit_count), 32'(hc));
    chk("miss_count", 32'(bus.miss_count), 32'(mc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busywait", 32'(bus.busywait), 0);
    chk("rst_mem_read", 32'(bus.mem_read), 0);
    chk("rst_mem_write", 32'(bus.mem_write), 0);
    chk("rst_mem_address", 32'(bus.mem_address), 0);
    chk("rst_mem_writedata", bus.mem_writedata, 0);
    chk("rst_counts", 32'({bus.hit_count, bus.miss_count}), 0);
    reset = 1'b0;

    // First miss, then a hit in the same line.
    do_req(1, 0, 8'h05, 8'h00);
    chk("lit_mra_05", 32'(last_mra), 32'h01);
    chk("lit_rd_05", 32'(last_rd), 32'hBB);
    chk("lit_miss_1", 32'(bus.miss_count), 1);
    do_req(1, 0, 8'h06, 8'h00);
    chk("lit_rd_06", 32'(last_rd), 32'hCC);
    chk("lit_hit_1", 32'(bus.hit_count), 1);

    // Fill set 1 and exercise LRU.
    do_req(1, 0, 8'h04, 8'h00);
    do_req(1, 0, 8'h24, 8'h00);
    do_req(1, 0, 8'h04, 8'h00);
    do_req(1, 0, 8'h44, 8'h00);
    do_req(1, 0, 8'h04, 8'h00);

    // Dirty a line on a hit, then evict it.
    do_req(1, 0, 8'h24, 8'h00);
    do_req(0, 1, 8'h25, 8'h5A);
    do_req(1, 0, 8'h04, 8'h00);
    do_req(1, 0, 8'h44, 8'h00);
    chk("lit_wb_addr_09", 32'(last_wba), 32'h09);
    chk("lit_wb_byte1", 32'(last_wbd[15:8]), 32'h5A);
    do_req(1, 0, 8'h24, 8'h00);

    // Write miss on a clean victim: the byte is merged after the fill, and the line is dirty.
    do_req(0, 1, 8'h13, 8'h77);
    do_req(1, 0, 8'h13, 8'h00);
    chk("lit_rd_13", 32'(last_rd), 32'h77);
    do_req(1, 0, 8'h33, 8'h00);
    do_req(1, 0, 8'h53, 8'h00);
    chk("lit_wb_addr_04", 32'(last_wba), 32'h04);
    chk("lit_wb_byte3", 32'(last_wbd[31:24]), 32'h77);

    // Reset in the third cycle of MEM_READ.
    bus.read    = 1'b1;
    bus.address = 8'hE8;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_mem_read", 32'(bus.mem_read), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_mem_read", 32'(bus.mem_read), 0);
    chk("rst_mid_mem_address", 32'(bus.mem_address), 0);
    chk("rst_mid_counts", 32'({bus.hit_count, bus.miss_count}), 0);
    @(negedge clk);
    reset    = 1'b0;
    bus.read = 1'b0;
    model_reset();
    do_req(1, 0, 8'h E8, 8'h00);
    chk("lit_post_rst_miss", 32'(bus.miss_count), 1);

    // read and write both high: no request.
    bus.read      = 1'b1;
    bus.write     = 1'b1;
    bus.address   = 8'hE9;
    bus.writedata = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("both_busywait", 32'(bus.busywait), 0);
      chk("both_mem", 32'({bus.mem_read, bus.mem_write}), 0);
      chk("both_readdata", 32'(bus.readdata), 0);
      @(negedge clk);
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
    #1;
    chk("both_hit_count", 32'(bus.hit_count), 32'(hc));
    chk("both_miss_count", 32'(bus.miss_count), 32'(mc));
    do_req(1, 0, 8'hE9, 8'h00);

    // Saturation of the 4-bit hit counter.
    repeat (17) do_req(1, 0, 8'hE8, 8'h00);
    chk("lit_hit_sat", 32'(bus.hit_count), 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
